// File: rtl/my_ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_ws2812_pkg
//  Description : Shared types and default constants for the WS2812/SK6812
//                chain driver (state encoding, 100 MHz timing defaults,
//                legal pixel widths, small elaboration helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package my_ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_HIGH    = 3'd2,
    ST_LOW     = 3'd3,
    ST_LATCH   = 3'd4
  } state_t;

  // Default timing at 100 MHz (1.2 us bit, 0.3/0.9 us highs, 60 us latch)
  localparam int DEF_NUM_LEDS     = 64;
  localparam int DEF_BITS_PER_LED = 24;
  localparam int DEF_T_BIT        = 120;
  localparam int DEF_T0H          = 30;
  localparam int DEF_T1H          = 90;
  localparam int DEF_T_RST        = 6000;

  // Legal pixel widths: GRB and GRBW
  localparam int BPL_GRB  = 24;
  localparam int BPL_GRBW = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/my_ws2812_bit.sv
`default_nettype none
// ============================================================================
//  Module      : my_ws2812_bit
//  Description : Single WS2812 bit-symbol generator. A go pulse starts one
//                T_BIT-cycle symbol whose high phase length depends on the
//                captured bit; strobes mark the last high and last cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_ws2812_bit #(
  parameter int T_BIT = 120,
  parameter int T0H   = 30,
  parameter int T1H   = 90,
  parameter int CW    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic bit_val,
  output logic line,
  output logic high_last,
  output logic last
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] th;
  logic          active;
  logic          bit_q;

  assign cnt_inc   = cnt + CW'(1);
  assign th        = bit_q ? CW'(T1H) : CW'(T0H);
  assign high_last = active && (cnt == th - CW'(1));
  assign last      = active && (cnt == CW'(T_BIT - 1));

  // Symbol counter and registered line: high for th cycles, low for the rest
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      bit_q  <= 1'b0;
      line   <= 1'b0;
    end else if (go) begin
      cnt    <= '0;
      active <= 1'b1;
      bit_q  <= bit_val;
      line   <= 1'b1;
    end else if (active) begin
      if (last) begin
        cnt    <= '0;
        active <= 1'b0;
        line   <= 1'b0;
      end else begin
        cnt    <= cnt_inc;
        line   <= (cnt_inc < th);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/my_ws2812_stream.sv
`default_nettype none
// ============================================================================
//  Module      : my_ws2812_stream
//  Description : WS2812/SK6812 chain driver. Pulls pixels from a valid/ready
//                stream through a one-entry prefetch buffer, serialises them
//                MSB-first with cycle-exact symbols and closes each frame
//                with a latch gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_ws2812_stream
  import my_ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BITS_PER_LED = DEF_BITS_PER_LED,
  parameter int T_BIT        = DEF_T_BIT,
  parameter int T0H          = DEF_T0H,
  parameter int T1H          = DEF_T1H,
  parameter int T_RST        = DEF_T_RST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BITS_PER_LED-1:0]     pix_data,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic                        ctrl,
  output logic                        busy,
  output logic                        done,
  output logic                        underrun,
  output logic [$clog2(NUM_LEDS)-1:0] led_idx
);

  localparam int CW = $clog2(max_int(T_BIT, T_RST) + 1);
  localparam int FW = $clog2(NUM_LEDS + 1);
  localparam int BW = $clog2(BITS_PER_LED);
  localparam int LW = $clog2(NUM_LEDS);
  localparam int B  = BITS_PER_LED;

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
    $error("my_ws2812_stream: need 0 < T0H < T1H < T_BIT");
  end
  if (B != BPL_GRB && B != BPL_GRBW) begin : g_bad_width
    $error("my_ws2812_stream: BITS_PER_LED must be 24 or 32");
  end
  if (NUM_LEDS < 2) begin : g_bad_leds
    $error("my_ws2812_stream: NUM_LEDS must be at least 2");
  end

  state_t        state, state_next;
  logic [B-1:0]  buf_data;
  logic          buf_full;
  logic [B-2:0]  shift_reg;   // bits still to send after the one in flight
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] fetched;
  logic [CW-1:0] latch_cnt;

  logic go, go_bit, load, step, next_led, start_frame, latch_start, frame_end;
  logic high_last, sym_last, accept;

  assign busy      = (state != ST_IDLE);
  assign pix_ready = busy && !buf_full && (fetched < FW'(NUM_LEDS));
  assign accept    = pix_valid && pix_ready;

  my_ws2812_bit #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H),
    .CW    (CW)
  ) u_bit (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .bit_val   (go_bit),
    .line      (ctrl),
    .high_last (high_last),
    .last      (sym_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next  = state;
    go          = 1'b0;
    go_bit      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    next_led    = 1'b0;
    start_frame = 1'b0;
    latch_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          state_next  = ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        if (buf_full) begin
          load       = 1'b1;
          go         = 1'b1;
          go_bit     = buf_data[B-1];
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (high_last) state_next = ST_LOW;
      end
      ST_LOW: begin
        if (sym_last) begin
          if (bit_idx == BW'(B - 1)) begin
            if (led_idx == LW'(NUM_LEDS - 1)) begin
              latch_start = 1'b1;
              state_next  = ST_LATCH;
            end else begin
              // LED boundary: an empty buffer sends an all-zero pixel
              load       = 1'b1;
              next_led   = 1'b1;
              go         = 1'b1;
              go_bit     = buf_full & buf_data[B-1];
              state_next = ST_HIGH;
            end
          end else begin
            step       = 1'b1;
            go         = 1'b1;
            go_bit     = shift_reg[B-2];
            state_next = ST_HIGH;
          end
        end
      end
      ST_LATCH: begin
        if (latch_cnt == CW'(T_RST - 1)) begin
          frame_end  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Prefetch buffer, shift register, LED/bit counters, latch timer, pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data  <= '0;
      buf_full  <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
      fetched   <= '0;
      led_idx   <= '0;
      latch_cnt <= '0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done     <= frame_end;
      underrun <= next_led && !buf_full;
      if (start_frame) begin
        fetched  <= '0;
        led_idx  <= '0;
        buf_full <= 1'b0;   // never carry a stale pixel into a new frame
      end else begin
        if (accept) begin
          buf_data <= pix_data;
          fetched  <= fetched + FW'(1);
        end
        if (load)        buf_full <= accept;
        else if (accept) buf_full <= 1'b1;
        if (next_led)    led_idx  <= led_idx + LW'(1);
      end
      if (load) begin
        shift_reg <= buf_full ? buf_data[B-2:0] : '0;
        bit_idx   <= '0;
      end else if (step) begin
        shift_reg <= shift_reg << 1;
        bit_idx   <= bit_idx + BW'(1);
      end
      if (latch_start)           latch_cnt <= '0;
      else if (state == ST_LATCH) latch_cnt <= latch_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_my_ws2812_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_ws2812_stream
//  Description : Directed self-checking bench for my_ws2812_stream with a
//                2-LED chain, 12-cycle bits (3/9 highs) and a 20-cycle latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_ws2812_stream;

  localparam int N    = 2;
  localparam int B    = 24;
  localparam int TB   = 12;
  localparam int T0   = 3;
  localparam int T1   = 9;
  localparam int TR   = 20;
  localparam int SYMS = N * B;
  localparam int FEND = SYMS * TB + TR;  // done cycle offset from first high

  logic          clk;
  logic          rst;
  logic          start;
  logic [B-1:0]  pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          ctrl;
  logic          busy;
  logic          done;
  logic          underrun;
  logic [0:0]    led_idx;

  my_ws2812_stream #(
    .NUM_LEDS     (N),
    .BITS_PER_LED (B),
    .T_BIT        (TB),
    .T0H          (T0),
    .T1H          (T1),
    .T_RST        (TR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .ctrl      (ctrl),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .led_idx   (led_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int acc1_cyc = -1;
  int acc2_cyc = -1;
  int inj_start = -1;

  logic [B-1:0] src [0:1];
  int           src_len = 0;
  int           src_idx = 0;
  logic         src_on  = 1'b0;

  logic rec_ctrl  [0:4095];
  logic rec_busy  [0:4095];
  logic rec_done  [0:4095];
  logic rec_under [0:4095];
  logic rec_ready [0:4095];
  logic rec_led   [0:4095];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note any handshake at the edge, sample outputs 1 ns later,
  // then present the next source pixel.
  task automatic tick();
    logic acc;
    acc = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      n_acc++;
      if (n_acc == 1) acc1_cyc = cyc;
      if (n_acc == 2) acc2_cyc = cyc;
      src_idx++;
    end
    pix_valid = src_on && (src_idx < src_len);
    pix_data  = (src_idx < src_len) ? src[src_idx] : '0;
    if (cyc < 4096) begin
      rec_ctrl[cyc]  = ctrl;
      rec_busy[cyc]  = busy;
      rec_done[cyc]  = done;
      rec_under[cyc] = underrun;
      rec_ready[cyc] = pix_ready;
      rec_led[cyc]   = led_idx[0];
    end
  endtask

  task automatic wait_ctrl_rise(input string tag, output int t);
    int n;
    n = 0;
    while (ctrl !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ctrl_rise"}, {31'd0, ctrl === 1'b1}, 32'd1);
    t = cyc;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) begin
      start = (cyc == inj_start);
      tick();
    end
    start = 1'b0;
  endtask

  function automatic int high_count(input int t0, input int s);
    int h;
    h = 0;
    for (int k = 0; k < TB; k++) if (rec_ctrl[t0 + s*TB + k] === 1'b1) h++;
    return h;
  endfunction

  // Compare a captured frame against the symbols the given pixels require
  task automatic check_frame(input string tag, input int t0, input logic [B-1:0] e0,
                             input logic [B-1:0] e1, input int exp_under);
    int bad_sym, bad_latch, n_done, n_under;
    logic [B-1:0] p;
    logic         b;
    bad_sym = 0;
    for (int s = 0; s < SYMS; s++) begin
      p = (s < B) ? e0 : e1;
      b = p[B - 1 - (s % B)];
      for (int k = 0; k < TB; k++)
        if (rec_ctrl[t0 + s*TB + k] !== (k < (b ? T1 : T0))) bad_sym++;
    end
    check({tag, "_symbols"}, bad_sym, 0);
    bad_latch = 0;
    for (int c = t0 + SYMS*TB; c < t0 + FEND; c++)
      if (rec_ctrl[c] !== 1'b0 || rec_busy[c] !== 1'b1 || rec_done[c] !== 1'b0) bad_latch++;
    check({tag, "_latch_gap"}, bad_latch, 0);
    n_done = 0;
    n_under = 0;
    for (int c = t0; c < t0 + FEND; c++) begin
      if (rec_done[c] === 1'b1) n_done++;
      if (rec_under[c] === 1'b1) n_under++;
    end
    check({tag, "_early_done"}, n_done, 0);
    check({tag, "_underruns"}, n_under, exp_under);
    if (exp_under > 0) check({tag, "_underrun_at_led1"}, {31'd0, rec_under[t0 + B*TB]}, 32'd1);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t0;
    int bad;
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;

    // Reset, then idle with a valid pixel offered: nothing may move
    repeat (3) tick();
    rst = 1'b0;
    src[0] = 24'hFF0000;
    src[1] = 24'h000001;
    src_len = 2;
    src_idx = 0;
    src_on = 1'b1;
    pix_valid = 1'b1;
    pix_data = src[0];
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({ctrl, busy, done, pix_ready, underrun, led_idx} !== 6'b0) bad++;
    end
    check("reset_idle_outputs", bad, 0);
    check("reset_ctrl", {31'd0, ctrl}, 32'd0);
    check("idle_no_accept", n_acc, 0);

    // Frame 1: 0xFF0000, 0x000001 with valid held high, stray start mid-frame
    n_acc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f1_busy_after_start", {31'd0, busy}, 32'd1);
    check("f1_ready_after_start", {31'd0, pix_ready}, 32'd1);
    wait_ctrl_rise("f1", t0);
    check("f1_rise_after_accept", t0 - acc1_cyc, 1);
    check("f1_ctrl_low_at_accept", {31'd0, rec_ctrl[acc1_cyc]}, 32'd0);
    inj_start = t0 + 100;
    run_until(t0 + FEND);
    inj_start = -1;
    check_frame("f1", t0, 24'hFF0000, 24'h000001, 0);
    check("f1_led0_bit0_high", high_count(t0, 0), T1);
    check("f1_led0_bit0_low_start", {31'd0, rec_ctrl[t0 + T1]}, 32'd0);
    check("f1_led0_bit8_high", high_count(t0, 8), T0);
    check("f1_led1_bit23_high", high_count(t0, SYMS - 1), T1);
    check("f1_second_accept_in_led0",
          {31'd0, (acc2_cyc > t0) && (acc2_cyc < t0 + B*TB)}, 32'd1);
    bad = 0;
    for (int c = acc2_cyc; c <= t0 + FEND; c++) if (rec_ready[c] !== 1'b0) bad++;
    check("f1_ready_low_after_two", bad, 0);
    check("f1_accepts", n_acc, 2);
    check("f1_led_idx_led0", {31'd0, rec_led[t0 + 10]}, 32'd0);
    check("f1_led_idx_led1", {31'd0, rec_led[t0 + 300]}, 32'd1);

    // Frame 2 starts in the done cycle; only one pixel supplied -> underrun
    src[0] = 24'hFFFFFF;
    src_len = 1;
    src_idx = 0;
    n_acc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f2_busy_after_done_start", {31'd0, busy}, 32'd1);
    check("f1_done_one_cycle", {31'd0, done}, 32'd0);
    wait_ctrl_rise("f2", t0);
    run_until(t0 + FEND);
    check_frame("f2", t0, 24'hFFFFFF, 24'h000000, 1);
    check("f2_accepts", n_acc, 1);

    // Frame 3: reset during LED1 bit 5 high phase
    src[0] = 24'hAAAAAA;
    src[1] = 24'h555555;
    src_len = 2;
    src_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ctrl_rise("f3", t0);
    run_until(t0 + (B + 5)*TB + 1);
    check("f3_high_before_rst", {31'd0, ctrl}, 32'd1);
    rst = 1'b1;
    src_on = 1'b0;
    tick();
    check("f3_rst_outputs", {26'd0, ctrl, busy, done, pix_ready, underrun, led_idx}, 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || ctrl !== 1'b0) bad++;
    end
    check("f3_no_done_after_rst", bad, 0);

    // Frame 4: fresh complete frame after the reset
    src[0] = 24'h123456;
    src[1] = 24'hABCDEF;
    src_len = 2;
    src_idx = 0;
    src_on = 1'b1;
    n_acc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ctrl_rise("f4", t0);
    run_until(t0 + FEND);
    check_frame("f4", t0, 24'h123456, 24'hABCDEF, 0);
    check("f4_accepts", n_acc, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
